enc_dec_share_arb: RTL and testbench

- Arbitration and sequencing controller that lets two requesters share one encoder128/decoder128 pair instead of instantiating a pair per channel.
- Accepts 128-bit words from two requesters with valid/ready handshakes and round-robin arbitration.
- Drives the external shared encoder through a registered pipeline (input reg -> code reg -> decoder).
- Steers each decoded result into a per-requester response FIFO, using credit-based backpressure.

---
 rtl/enc_dec_share_arb.sv | 199 +++++++++++++++++++
 tb/tb_enc_dec_share_arb.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_dec_share_arb.sv
// Two-requester front end for one shared encoder/decoder pair: round-robin grant, two-stage pipeline, credited response FIFOs.
// Optional grant/stall counters are built when ENC_DEC_SHARE_STATS_EN is defined.
module enc_dec_share_arb #(
   parameter int DATA_W    = 128,
   parameter int CODE_W    = 7,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   output logic [DATA_W-1:0] enc_in,
   input  logic [CODE_W-1:0] enc_code,
   output logic [CODE_W-1:0] dec_code,
   input  logic [DATA_W-1:0] dec_data,
   output logic              busy
`ifdef ENC_DEC_SHARE_STATS_EN
   ,
   output logic [15:0]       stat_gnt0,
   output logic [15:0]       stat_gnt1,
   output logic [15:0]       stat_stall
`endif
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

   logic              last_q, last_d;
   logic [DATA_W-1:0] enc_in_q, enc_in_d;
   logic              s1_valid_q, s1_valid_d, s1_tag_q, s1_tag_d;
   logic [CODE_W-1:0] dec_code_q, dec_code_d;
   logic              s2_valid_q, s2_valid_d, s2_tag_q, s2_tag_d;
   logic [DATA_W-1:0] mem_q [2][RSP_DEPTH];
   logic [DATA_W-1:0] mem_d [2][RSP_DEPTH];
   logic [PW-1:0]     wr_ptr_q [2];
   logic [PW-1:0]     wr_ptr_d [2];
   logic [PW-1:0]     rd_ptr_q [2];
   logic [PW-1:0]     rd_ptr_d [2];
   logic [CW-1:0]     cnt_q [2];
   logic [CW-1:0]     cnt_d [2];
   logic [CW-1:0]     credit_q [2];
   logic [CW-1:0]     credit_d [2];
   logic [1:0]        elig_s, gnt_s, push_s, pop_s, rsp_ready_s;

   // Eligibility and round-robin grant; last_q=1 means requester 1 won last, so requester 0 wins a tie.
   always_comb begin
      elig_s[0] = req0_valid & (credit_q[0] < DEPTH_C);
      elig_s[1] = req1_valid & (credit_q[1] < DEPTH_C);
      gnt_s[0]  = reset & elig_s[0] & (~elig_s[1] | last_q);
      gnt_s[1]  = reset & elig_s[1] & (~elig_s[0] | ~last_q);
      if (gnt_s[1]) begin
         last_d = 1'b1;
      end else if (gnt_s[0]) begin
         last_d = 1'b0;
      end else begin
         last_d = last_q;
      end
   end

   // Pipeline stages: accepted word into encoder register, code into decoder register.
   always_comb begin
      if (gnt_s[1]) begin
         enc_in_d = req1_data;
         s1_tag_d = 1'b1;
      end else if (gnt_s[0]) begin
         enc_in_d = req0_data;
         s1_tag_d = 1'b0;
      end else begin
         enc_in_d = enc_in_q;
         s1_tag_d = s1_tag_q;
      end
      s1_valid_d = |gnt_s;
      dec_code_d = enc_code;
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
   end

   // Response FIFOs and credits; credits count FIFO occupancy plus words still in the pipeline.
   always_comb begin
      rsp_ready_s = {rsp1_ready, rsp0_ready};
      mem_d       = mem_q;
      for (int r = 0; r < 2; r++) begin
         push_s[r] = s2_valid_q & (s2_tag_q == 1'(r));
         pop_s[r]  = (cnt_q[r] != {CW{1'b0}}) & rsp_ready_s[r];
         if (push_s[r]) begin
            mem_d[r][wr_ptr_q[r]] = dec_data;
            wr_ptr_d[r]           = wr_ptr_q[r] + PW'(1);
         end else begin
            wr_ptr_d[r] = wr_ptr_q[r];
         end
         if (pop_s[r]) begin
            rd_ptr_d[r] = rd_ptr_q[r] + PW'(1);
         end else begin
            rd_ptr_d[r] = rd_ptr_q[r];
         end
         cnt_d[r]    = cnt_q[r] + {{PW{1'b0}}, push_s[r]} - {{PW{1'b0}}, pop_s[r]};
         credit_d[r] = credit_q[r] + {{PW{1'b0}}, gnt_s[r]} - {{PW{1'b0}}, pop_s[r]};
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q     <= 1'b1;
         enc_in_q   <= {DATA_W{1'b0}};
         s1_valid_q <= 1'b0;
         s1_tag_q   <= 1'b0;
         dec_code_q <= {CODE_W{1'b0}};
         s2_valid_q <= 1'b0;
         s2_tag_q   <= 1'b0;
         for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < RSP_DEPTH; k++) begin
               mem_q[r][k] <= {DATA_W{1'b0}};
            end
            wr_ptr_q[r] <= {PW{1'b0}};
            rd_ptr_q[r] <= {PW{1'b0}};
            cnt_q[r]    <= {CW{1'b0}};
            credit_q[r] <= {CW{1'b0}};
         end
      end else begin
         last_q     <= last_d;
         enc_in_q   <= enc_in_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         dec_code_q <= dec_code_d;
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         credit_q   <= credit_d;
      end
   end

   assign req0_ready = gnt_s[0];
   assign req1_ready = gnt_s[1];
   assign rsp0_valid = (cnt_q[0] != {CW{1'b0}});
   assign rsp1_valid = (cnt_q[1] != {CW{1'b0}});
   assign rsp0_data  = mem_q[0][rd_ptr_q[0]];
   assign rsp1_data  = mem_q[1][rd_ptr_q[1]];
   assign enc_in     = enc_in_q;
   assign dec_code   = dec_code_q;
   assign busy       = s1_valid_q | s2_valid_q | rsp0_valid | rsp1_valid;

`ifdef ENC_DEC_SHARE_STATS_EN
   logic [15:0] stat_gnt0_q, stat_gnt0_d, stat_gnt1_q, stat_gnt1_d, stat_stall_q, stat_stall_d;
   logic        stall_s;

   // Saturating grant and stall counters.
   always_comb begin
      stall_s = (req0_valid & (credit_q[0] == DEPTH_C)) | (req1_valid & (credit_q[1] == DEPTH_C));
      if (gnt_s[0] && (stat_gnt0_q != 16'hFFFF)) begin
         stat_gnt0_d = stat_gnt0_q + 16'd1;
      end else begin
         stat_gnt0_d = stat_gnt0_q;
      end
      if (gnt_s[1] && (stat_gnt1_q != 16'hFFFF)) begin
         stat_gnt1_d = stat_gnt1_q + 16'd1;
      end else begin
         stat_gnt1_d = stat_gnt1_q;
      end
      if (stall_s && (stat_stall_q != 16'hFFFF)) begin
         stat_stall_d = stat_stall_q + 16'd1;
      end else begin
         stat_stall_d = stat_stall_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_gnt0_q  <= 16'd0;
         stat_gnt1_q  <= 16'd0;
         stat_stall_q <= 16'd0;
      end else begin
         stat_gnt0_q  <= stat_gnt0_d;
         stat_gnt1_q  <= stat_gnt1_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_gnt0  = stat_gnt0_q;
   assign stat_gnt1  = stat_gnt1_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_enc_dec_share_arb.sv
// Scoreboard bench for enc_dec_share_arb; the shared codec is modelled as a priority encoder and a one-hot decoder.
module tb_enc_dec_share_arb;
   localparam int DW = 128;
   localparam int CW = 7;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic [DW-1:0] enc_in, dec_data;
   logic [CW-1:0] enc_code, dec_code;
   logic          busy;
`ifdef ENC_DEC_SHARE_STATS_EN
   logic [15:0]   stat_gnt0, stat_gnt1, stat_stall;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit lat_chk = 1'b0;
   logic [DW-1:0] exp_q0[$], exp_q1[$];
   int cyc_q0[$], cyc_q1[$];

   enc_dec_share_arb dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .enc_in(enc_in), .enc_code(enc_code), .dec_code(dec_code), .dec_data(dec_data),
      .busy(busy)
`ifdef ENC_DEC_SHARE_STATS_EN
      , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_stall(stat_stall)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [CW-1:0] msb_idx(input logic [DW-1:0] d);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) if (d[i]) r = CW'(i);
      return r;
   endfunction

   function automatic logic [DW-1:0] onehot(input int i);
      logic [DW-1:0] v;
      v = '0;
      v[i % DW] = 1'b1;
      return v;
   endfunction

   always_comb enc_code = msb_idx(enc_in);
   always_comb dec_data = DW'(1) << dec_code;

   // Scoreboard: push expected round trip on accept, compare on pop (sampled mid-cycle).
   always @(negedge clock) begin
      logic [DW-1:0] e;
      int c;
      if (reset) begin
         if (req0_valid && req0_ready) begin
            exp_q0.push_back(DW'(1) << msb_idx(req0_data));
            cyc_q0.push_back(cyc);
         end
         if (req1_valid && req1_ready) begin
            exp_q1.push_back(DW'(1) << msb_idx(req1_data));
            cyc_q1.push_back(cyc);
         end
         if (rsp0_valid && rsp0_ready) begin
            checks++;
            if (exp_q0.size() == 0) begin
               errors++;
               $display("FAIL rsp0_unexpected: got %h, required no response", rsp0_data);
            end else begin
               e = exp_q0.pop_front();
               c = cyc_q0.pop_front();
               if (rsp0_data !== e) begin
                  errors++;
                  $display("FAIL rsp0_data: got %h, required %h", rsp0_data, e);
               end
               if (lat_chk) begin
                  checks++;
                  if (cyc - c !== 3) begin
                     errors++;
                     $display("FAIL rsp0_latency: got %0d, required 3", cyc - c);
                  end
               end
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            checks++;
            if (exp_q1.size() == 0) begin
               errors++;
               $display("FAIL rsp1_unexpected: got %h, required no response", rsp1_data);
            end else begin
               e = exp_q1.pop_front();
               c = cyc_q1.pop_front();
               if (rsp1_data !== e) begin
                  errors++;
                  $display("FAIL rsp1_data: got %h, required %h", rsp1_data, e);
               end
               if (lat_chk) begin
                  checks++;
                  if (cyc - c !== 3) begin
                     errors++;
                     $display("FAIL rsp1_latency: got %0d, required 3", cyc - c);
                  end
               end
            end
         end
      end
   end

   task automatic flush_sb();
      exp_q0.delete(); exp_q1.delete(); cyc_q0.delete(); cyc_q1.delete();
   endtask

   task automatic apply_reset();
      @(posedge clock); #1;
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      flush_sb();
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic idle(input int n);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = onehot(5); req1_data = onehot(6);
      repeat (2) @(posedge clock);
      #1;
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b, required 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready: got %b, required 0", req1_ready); end
      checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp0_valid: got %b, required 0", rsp0_valid); end
      checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp1_valid: got %b, required 0", rsp1_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      checks++; if (enc_in !== '0) begin errors++; $display("FAIL rst_enc_in: got %h, required 0", enc_in); end
      checks++; if (dec_code !== '0) begin errors++; $display("FAIL rst_dec_code: got %h, required 0", dec_code); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic test_alternate();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      lat_chk = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clock); #1;
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_data = onehot(2 * k + 1); req1_data = onehot(100 - k);
         #1;
         checks++;
         if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
            errors++;
            $display("FAIL alt_grant[%0d]: got r0=%b r1=%b, required r0=%b r1=%b", k, req0_ready, req1_ready, (k % 2 == 0), (k % 2 == 1));
         end
         checks++;
         if (dut.credit_q[0] > 2 || dut.credit_q[1] > 2) begin
            errors++;
            $display("FAIL alt_credit[%0d]: got c0=%0d c1=%0d, required <= 2", k, dut.credit_q[0], dut.credit_q[1]);
         end
      end
      idle(6);
      lat_chk = 1'b0;
   endtask

   task automatic test_single();
      @(posedge clock); #1;
      req0_valid = 1'b1; req0_data = 128'h8000_0000;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready); end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      checks++; if (enc_in !== 128'h8000_0000) begin errors++; $display("FAIL single_enc_in: got %h, required 80000000", enc_in); end
      checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_e0: got rsp0_valid=%b busy=%b, required 0 1", rsp0_valid, busy); end
      @(posedge clock); #1;
      checks++; if (dec_code !== 7'd31) begin errors++; $display("FAIL single_dec_code: got %0d, required 31", dec_code); end
      checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b, required 0", rsp0_valid); end
      @(posedge clock); #1;
      checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 128'h8000_0000) begin errors++; $display("FAIL single_rsp0: got valid=%b data=%h, required 1 80000000", rsp0_valid, rsp0_data); end
      checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_idle: got %b, required 0", rsp1_valid); end
      idle(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy); end
   endtask

   task automatic test_backpressure();
      int n1;
      bit seen;
      n1 = 0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_data = onehot(k + 7); req1_data = onehot(3 * k + 40);
         #1;
         if (req1_ready) n1++;
         if (k >= 12) begin
            checks++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_grant[%0d]: got r0=%b r1=%b, required r0=1 r1=0", k, req0_ready, req1_ready);
            end
         end
      end
      checks++; if (n1 != 4) begin errors++; $display("FAIL bp_req1_accepts: got %0d, required 4", n1); end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clock); #1;
         rsp1_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b1; req1_data = onehot(90 + k);
         #1;
         if (req1_ready) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL bp_resume: got no req1 grant, required a grant within 10 cycles"); end
      @(posedge clock); #1;
      idle(10);
   endtask

   task automatic test_full_pop();
      int n1;
      n1 = 0;
      rsp1_ready = 1'b0; req0_valid = 1'b0;
      for (int k = 0; k < 10 && n1 < 4; k++) begin
         @(posedge clock); #1;
         req1_valid = 1'b1; req1_data = onehot(10 + k);
         #1;
         if (req1_ready) n1++;
      end
      repeat (5) @(posedge clock);
      #1;
      rsp1_ready = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b0 || rsp1_valid !== 1'b1) begin errors++; $display("FAIL full_pop_same_cycle: got ready=%b rsp1_valid=%b, required 0 1", req1_ready, rsp1_valid); end
      @(posedge clock); #1;
      req1_data = onehot(77);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL full_pop_next_cycle: got %b, required 1", req1_ready); end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      checks++; if (dut.credit_q[1] !== 3'd3) begin errors++; $display("FAIL accept_pop_credit: got %0d, required 3", dut.credit_q[1]); end
      idle(10);
   endtask

   task automatic test_reset_mid();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(posedge clock); #1;
      req0_valid = 1'b1; req0_data = onehot(20);
      @(posedge clock); #1;
      req0_data = onehot(21);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got r0=%b r1=%b, required 0 0", req0_ready, req1_ready); end
      checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got busy=%b v0=%b v1=%b, required 0 0 0", busy, rsp0_valid, rsp1_valid); end
      flush_sb();
      @(posedge clock); #1;
      reset = 1'b1; req0_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         checks++;
         if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale[%0d]: got busy=%b v0=%b v1=%b, required 0 0 0", k, busy, rsp0_valid, rsp1_valid);
         end
      end
   endtask

`ifdef ENC_DEC_SHARE_STATS_EN
   task automatic test_stats();
      int n1;
      logic [15:0] s0;
      apply_reset();
      checks++; if (stat_gnt0 !== 16'd0 || stat_stall !== 16'd0) begin errors++; $display("FAIL stat_reset: got g0=%0d st=%0d, required 0 0", stat_gnt0, stat_stall); end
      rsp0_ready = 1'b1;
      req0_valid = 1'b1; req0_data = onehot(3);
      repeat (70000) @(posedge clock);
      #1;
      req0_valid = 1'b0;
      checks++; if (stat_gnt0 !== 16'hFFFF || stat_gnt1 !== 16'd0) begin errors++; $display("FAIL stat_gnt_sat: got g0=%h g1=%h, required ffff 0", stat_gnt0, stat_gnt1); end
      idle(6);
      n1 = 0;
      rsp1_ready = 1'b0;
      for (int k = 0; k < 10 && n1 < 4; k++) begin
         @(posedge clock); #1;
         req1_valid = 1'b1; req1_data = onehot(50 + k);
         #1;
         if (req1_ready) n1++;
      end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      @(posedge clock); #1;
      s0 = stat_stall;
      req1_valid = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      req1_valid = 1'b0;
      checks++; if (stat_stall - s0 !== 16'd10) begin errors++; $display("FAIL stat_stall: got %0d, required 10", stat_stall - s0); end
      rsp1_ready = 1'b1;
      idle(10);
   endtask
`endif

   initial begin
      test_reset();
      test_alternate();
      test_single();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
`ifdef ENC_DEC_SHARE_STATS_EN
      test_stats();
`endif
      idle(4);
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain_end: got %0d/%0d outstanding, required 0/0", exp_q0.size(), exp_q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
